// File: rtl/rr_select_pkg.sv
// Shared types and constants for the round-robin select arbiter.
package rr_select_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } state_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set request at or after ptr, wrapping modulo 4.
module rr_pick
  import rr_select_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   off;

  // rot[i] = req[(i + ptr) % 4], so bit 0 is always the highest priority.
  always_comb begin
    rot = '0;
    case (ptr)
      2'd0:    rot = req;
      2'd1:    rot = {req[0],   req[3:1]};
      2'd2:    rot = {req[1:0], req[3:2]};
      2'd3:    rot = {req[2:0], req[3]};
      default: rot = req;
    endcase
  end

  always_comb begin
    off = '0;
    casez (rot)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
  end

  assign found = |rot;
  assign idx   = ptr + off;

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter owning a 2-bit mux select bus and a registered shared output bit.
// Define ARB_TIMEOUT_EN to enforce the HOLD_CYCLES grant-length limit.
module rr_select_arbiter
  import rr_select_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] data_in,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               y,
  output logic               busy
);

  if (HOLD_CYCLES == 0 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("rr_select_arbiter: HOLD_CYCLES must be in 1..255");
  end

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               sel_valid_q, sel_valid_d;
  logic               y_q, y_d;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               hold_done;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign hold_done = (cnt_q == HOLD_LAST);
`else
  assign hold_done = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    grant_d     = grant_q;
    sel_valid_d = sel_valid_q;
    y_d         = sel_valid_q ? data_in[sel_q] : 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d       = pick_idx;
          grant_d     = idx_to_onehot(pick_idx);
          sel_valid_d = 1'b1;
          state_d     = GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      GRANT: begin
`ifdef ARB_TIMEOUT_EN
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`endif
        // A req drop coinciding with timeout is still a single exit.
        if (!req[sel_q] || hold_done) begin
          state_d     = RELEASE;
          grant_d     = '0;
          sel_valid_d = 1'b0;
        end
      end
      RELEASE: begin
        ptr_d       = sel_q + 1'b1;
        grant_d     = '0;
        sel_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        grant_d     = '0;
        sel_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      grant_q     <= '0;
      sel_valid_q <= 1'b0;
      y_q         <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      sel_valid_q <= sel_valid_d;
      y_q         <= y_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign y         = y_q;
  assign busy      = (state_q == GRANT) || (state_q == RELEASE);

endmodule
